// File: rtl/lfsr_pattern_monitor_if.sv
// Connection bundle between the LFSR pattern monitor and its neighbour.
// The neighbour side holds the master modport. It drives the run request and
// the serial bit, and it samples the shift enable and the statistics.
// Optional macro LFSR_MON_HOLD_EN adds the hold request to the bundle.
interface lfsr_pattern_monitor_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 17
);
  logic             start;
  logic             bit_in;
`ifdef LFSR_MON_HOLD_EN
  logic             hold;
`endif
  logic             sh_en;
  logic             busy;
  logic             done;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic [PAT_W-1:0] window;

`ifdef LFSR_MON_HOLD_EN
  modport master (output start, bit_in, hold,
                  input  sh_en, busy, done, match_pulse, match_count, window);
  modport slave  (input  start, bit_in, hold,
                  output sh_en, busy, done, match_pulse, match_count, window);
`else
  modport master (output start, bit_in,
                  input  sh_en, busy, done, match_pulse, match_count, window);
  modport slave  (input  start, bit_in,
                  output sh_en, busy, done, match_pulse, match_count, window);
`endif
endinterface

// File: rtl/lfsr_pattern_monitor.sv
// LFSR pattern monitor.
// The monitor drives the LFSR shift enable for RUN_LEN cycles and shifts each
// serial bit into a sliding window. It counts window == PATTERN matches,
// including overlapping ones, into a saturating counter.
// Optional macro LFSR_MON_HOLD_EN adds a hold input. Hold pauses a run in
// place, and no bit is lost when the run resumes.
module lfsr_pattern_monitor #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = 8'b10110011,
  parameter int               RUN_LEN = 131071,
  parameter int               CNT_W   = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lfsr_pattern_monitor_if.slave mon
);

  // The shift counter is CNT_W wide. It is widened when CNT_W is too narrow
  // to hold RUN_LEN-1.
  localparam int                SH_W       = (CNT_W > $clog2(RUN_LEN)) ? CNT_W : $clog2(RUN_LEN);
  localparam int                FILL_W     = $clog2(PAT_W + 1);
  localparam logic [SH_W-1:0]   LAST_SHIFT = SH_W'(RUN_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM   = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [SH_W-1:0]   shift_cnt;
  logic [FILL_W-1:0] fill_cnt;
  logic [PAT_W-1:0]  window_q;
  logic [CNT_W-1:0]  match_count_q;
  logic              busy_q;
  logic              done_q;
  logic              match_pulse_q;

  logic              hold_req;
  logic              shift;
  logic [PAT_W-1:0]  next_window;
  logic              is_match;

`ifdef LFSR_MON_HOLD_EN
  assign hold_req = mon.hold;
`else
  assign hold_req = 1'b0;
`endif

  // sh_en is combinational, so the LFSR advances on the same edge that
  // captures its current bit.
  assign shift       = (state == RUN) && !hold_req;
  assign next_window = {window_q[PAT_W-2:0], mon.bit_in};
  // A match is valid only when the bit entering now completes a full window.
  assign is_match    = (next_window == PATTERN) && (fill_cnt >= FILL_ARM);

  assign mon.sh_en       = shift;
  assign mon.busy        = busy_q;
  assign mon.done        = done_q;
  assign mon.match_pulse = match_pulse_q;
  assign mon.match_count = match_count_q;
  assign mon.window      = window_q;

  // Run control FSM together with the window, fill, shift and match registers.
  // NOTE: every register here uses <=, so all branches see the pre-edge
  // values. For example, the last-shift compare and the counter increment
  // read the same shift_cnt.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      // rst_n is asserted high and takes effect only on the clock edge.
      state         <= IDLE;
      shift_cnt     <= '0;
      fill_cnt      <= '0;
      window_q      <= '0;
      match_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      match_pulse_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q        <= 1'b0;
          match_pulse_q <= 1'b0;
          if (mon.start) begin
            state         <= RUN;
            busy_q        <= 1'b1;
            shift_cnt     <= '0;
            fill_cnt      <= '0;
            window_q      <= '0;
            match_count_q <= '0;
          end
        end
        RUN: begin
          if (shift) begin
            window_q      <= next_window;
            match_pulse_q <= is_match;
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
            if (is_match && (match_count_q != '1)) match_count_q <= match_count_q + 1'b1;
            if (shift_cnt == LAST_SHIFT) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end else begin
            match_pulse_q <= 1'b0;
          end
        end
        DONE: begin
          state         <= IDLE;
          done_q        <= 1'b0;
          match_pulse_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_pattern_monitor.sv
// Bench for lfsr_pattern_monitor.
// dut_a uses a 4-bit pattern 1011 with a 12-shift run.
// dut_b uses a 2-bit pattern 11, an 8-shift run and a 2-bit saturating count.
// A reference model pushes the expected window, pulse and count for every
// shift. Those entries are popped and compared on the following cycle.
// Building with LFSR_MON_HOLD_EN adds the hold scenario.
`timescale 1ns/1ps
module tb_lfsr_pattern_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] window;
    logic       pulse;
    logic [7:0] count;
    int         idx;
  } exp_a_t;

  typedef struct {
    logic [1:0] window;
    logic       pulse;
    logic [1:0] count;
  } exp_b_t;

  exp_a_t q_a[$];
  exp_b_t q_b[$];
  logic [11:0] stream_a;

  lfsr_pattern_monitor_if #(.PAT_W(4), .CNT_W(8)) ifa ();
  lfsr_pattern_monitor_if #(.PAT_W(2), .CNT_W(2)) ifb ();

  lfsr_pattern_monitor #(.PAT_W(4), .PATTERN(4'b1011), .RUN_LEN(12), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .mon(ifa));
  lfsr_pattern_monitor #(.PAT_W(2), .PATTERN(2'b11), .RUN_LEN(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mon(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one dut_a run and feed it the stream. Every shift is scored
  // against the model, and the task returns after the done cycle.
  task automatic run_a(input logic [11:0] stream, input int start_at,
                       input int hold_at, input int hold_len,
                       output int lat, output int n_shift,
                       output logic [11:0] pmask, output int done_cyc);
    exp_a_t     e;
    logic [3:0] w_m;
    logic [7:0] c_m;
    logic       b;
    logic       m;
    int         fill_m;
    int         holds_left;
    bit         hold_now;
    bit         started;
    bit         finished;
    lat = 0; n_shift = 0; pmask = '0; done_cyc = -1;
    w_m = '0; c_m = '0; fill_m = 0; holds_left = 0;
    started = 0; finished = 0;
    q_a.delete();
    ifa.start = 1'b1;
    for (int i = 1; i <= 4 && !started; i++) begin
      tick();
      if (ifa.sh_en === 1'b1) begin
        started = 1;
        lat = i;
      end
    end
    ifa.start = 1'b0;
    vectors++;
    if (!started) begin
      miscompares++;
      $display("FAIL run_a_launch: sh_en never rose within 4 cycles, required 1");
      return;
    end
    vectors++;
    if (ifa.match_count !== 8'd0 || ifa.window !== 4'd0) begin
      miscompares++;
      $display("FAIL run_a_clear: count=%0d window=%b, required 0 and 0000", ifa.match_count, ifa.window);
    end
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        vectors++;
        if (ifa.window !== e.window || ifa.match_pulse !== e.pulse || ifa.match_count !== e.count) begin
          miscompares++;
          $display("FAIL run_a_step%0d: window=%b pulse=%b count=%0d, required %b %b %0d",
                   e.idx, ifa.window, ifa.match_pulse, ifa.match_count, e.window, e.pulse, e.count);
        end
        if (e.idx > 0 && e.idx <= 12) pmask[e.idx-1] = ifa.match_pulse;
      end
      if (ifa.done === 1'b1) begin
        done_cyc = cyc;
        finished = 1;
        vectors++;
        if (ifa.busy !== 1'b0 || ifa.sh_en !== 1'b0) begin
          miscompares++;
          $display("FAIL run_a_done_flags: busy=%b sh_en=%b, required 0 0", ifa.busy, ifa.sh_en);
        end
      end else begin
        hold_now = (holds_left > 0);
        if (holds_left > 0) holds_left--;
`ifdef LFSR_MON_HOLD_EN
        ifa.hold = hold_now;
        #1;
`endif
        ifa.start = 1'b0;
        if (hold_now) begin
          vectors++;
          if (ifa.sh_en !== 1'b0) begin
            miscompares++;
            $display("FAIL run_a_hold_sh_en: sh_en=%b, required 0", ifa.sh_en);
          end
          e = '{window: w_m, pulse: 1'b0, count: c_m, idx: 0};
          q_a.push_back(e);
        end else if (ifa.sh_en === 1'b1) begin
          n_shift++;
          b = (n_shift <= 12) ? stream[n_shift-1] : 1'b0;
          ifa.bit_in = b;
          w_m = {w_m[2:0], b};
          m = (w_m == 4'b1011) && (fill_m + 1 >= 4);
          if (fill_m < 4) fill_m++;
          if (m && c_m != 8'hFF) c_m++;
          e = '{window: w_m, pulse: m, count: c_m, idx: n_shift};
          q_a.push_back(e);
          if (n_shift == start_at) ifa.start = 1'b1;
          if (n_shift == hold_at) holds_left = hold_len;
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL run_a_gap: sh_en=%b in cycle %0d of run, required 1", ifa.sh_en, cyc);
        end
        tick();
      end
    end
    ifa.start = 1'b0;
`ifdef LFSR_MON_HOLD_EN
    ifa.hold = 1'b0;
`endif
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL run_a_timeout: done=0 after 40 cycles, required 1");
    end
  endtask

  // Compare the run summary against the fixed expectations for stream_a.
  task automatic check_a_summary(input string tag, input int n_shift, input logic [11:0] pmask,
                                 input int done_cyc, input int want_done_cyc);
    vectors++;
    if (n_shift !== 12) begin
      miscompares++;
      $display("FAIL %s_shifts: %0d sh_en cycles, required 12", tag, n_shift);
    end
    vectors++;
    if (pmask !== 12'h248) begin
      miscompares++;
      $display("FAIL %s_pulse_pos: mask=%h, required 248 (shifts 4,7,10)", tag, pmask);
    end
    vectors++;
    if (ifa.match_count !== 8'd3 || ifa.window !== 4'b1111) begin
      miscompares++;
      $display("FAIL %s_final: count=%0d window=%b, required 3 1111", tag, ifa.match_count, ifa.window);
    end
    vectors++;
    if (done_cyc !== want_done_cyc) begin
      miscompares++;
      $display("FAIL %s_done_time: done after %0d cycles, required %0d", tag, done_cyc, want_done_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ifa.start = 1'b1;
    ifb.start = 1'b1;
    tick();
    tick();
    vectors++;
    if ({ifa.sh_en, ifa.busy, ifa.done, ifa.match_pulse} !== 4'b0 || ifa.match_count !== 8'd0 || ifa.window !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_a: sh_en/busy/done/pulse=%b count=%0d window=%b, required all 0",
               {ifa.sh_en, ifa.busy, ifa.done, ifa.match_pulse}, ifa.match_count, ifa.window);
    end
    vectors++;
    if ({ifb.sh_en, ifb.busy, ifb.done, ifb.match_pulse} !== 4'b0 || ifb.match_count !== 2'd0 || ifb.window !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_b: sh_en/busy/done/pulse=%b count=%0d window=%b, required all 0",
               {ifb.sh_en, ifb.busy, ifb.done, ifb.match_pulse}, ifb.match_count, ifb.window);
    end
    ifb.start = 1'b0;
    rst_n = 1'b0;
    tick();
    vectors++;
    if (ifa.sh_en !== 1'b1 || ifa.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_start: sh_en=%b busy=%b, required 1 1", ifa.sh_en, ifa.busy);
    end
    ifa.start = 1'b0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    vectors++;
    if (ifa.sh_en !== 1'b0 || ifa.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: sh_en=%b busy=%b, required 0 0", ifa.sh_en, ifa.busy);
    end
    tick();
  endtask

  task automatic test_pattern_count();
    int lat, n_shift, done_cyc;
    logic [11:0] pmask;
    run_a(stream_a, -1, -1, 0, lat, n_shift, pmask, done_cyc);
    check_a_summary("pattern", n_shift, pmask, done_cyc, 12);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL pattern_latency: first sh_en %0d cycles after start, required 1", lat);
    end
    tick();
    vectors++;
    if (ifa.done !== 1'b0 || ifa.sh_en !== 1'b0 || ifa.match_count !== 8'd3) begin
      miscompares++;
      $display("FAIL pattern_after_done: done=%b sh_en=%b count=%0d, required 0 0 3",
               ifa.done, ifa.sh_en, ifa.match_count);
    end
    tick();
  endtask

  task automatic test_start_handling();
    int lat, n_shift, done_cyc;
    logic [11:0] pmask;
    // A start pulse mid-run must neither restart the run nor extend it.
    run_a(stream_a, 5, -1, 0, lat, n_shift, pmask, done_cyc);
    check_a_summary("start_in_run", n_shift, pmask, done_cyc, 12);
    // Start is raised in the DONE cycle and held. It takes effect from IDLE.
    run_a(stream_a, -1, -1, 0, lat, n_shift, pmask, done_cyc);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL start_in_done_latency: first sh_en %0d cycles after start, required 2", lat);
    end
    check_a_summary("start_in_done", n_shift, pmask, done_cyc, 12);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  started;
    bit  saw_done;
    started = 0;
    n = 0;
    saw_done = 0;
    ifa.start = 1'b1;
    for (int i = 0; i < 4 && !started; i++) begin
      tick();
      if (ifa.sh_en === 1'b1) started = 1;
    end
    ifa.start = 1'b0;
    for (int i = 0; i < 20 && started && n < 5; i++) begin
      if (ifa.sh_en === 1'b1) begin
        n++;
        ifa.bit_in = stream_a[n-1];
        if (n == 5) rst_n = 1'b1;
      end
      tick();
    end
    rst_n = 1'b0;
    vectors++;
    if (!started || n != 5) begin
      miscompares++;
      $display("FAIL reset_mid_reach: reached shift %0d, required 5", n);
    end
    vectors++;
    if ({ifa.sh_en, ifa.busy, ifa.done, ifa.match_pulse} !== 4'b0 || ifa.match_count !== 8'd0 || ifa.window !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid_state: sh_en/busy/done/pulse=%b count=%0d window=%b, required all 0",
               {ifa.sh_en, ifa.busy, ifa.done, ifa.match_pulse}, ifa.match_count, ifa.window);
    end
    for (int i = 0; i < 15; i++) begin
      if (ifa.done !== 1'b0 || ifa.sh_en !== 1'b0) saw_done = 1;
      tick();
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: done or sh_en rose after reset, required 0");
    end
  endtask

  task automatic test_saturation();
    exp_b_t     e;
    logic [1:0] w_m;
    logic [1:0] c_m;
    logic       m;
    int         fill_m;
    int         n_shift;
    int         pulses;
    bit         started;
    bit         finished;
    w_m = '0; c_m = '0; fill_m = 0; n_shift = 0; pulses = 0;
    started = 0; finished = 0;
    q_b.delete();
    ifb.bit_in = 1'b1;
    ifb.start  = 1'b1;
    for (int i = 0; i < 4 && !started; i++) begin
      tick();
      if (ifb.sh_en === 1'b1) started = 1;
    end
    ifb.start = 1'b0;
    for (int cyc = 0; cyc < 30 && started && !finished; cyc++) begin
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        vectors++;
        if (ifb.window !== e.window || ifb.match_pulse !== e.pulse || ifb.match_count !== e.count) begin
          miscompares++;
          $display("FAIL sat_step: window=%b pulse=%b count=%0d, required %b %b %0d",
                   ifb.window, ifb.match_pulse, ifb.match_count, e.window, e.pulse, e.count);
        end
        if (ifb.match_pulse === 1'b1) pulses++;
      end
      if (ifb.done === 1'b1) begin
        finished = 1;
      end else begin
        if (ifb.sh_en === 1'b1) begin
          n_shift++;
          w_m = {w_m[0], 1'b1};
          m = (w_m == 2'b11) && (fill_m + 1 >= 2);
          if (fill_m < 2) fill_m++;
          if (m && c_m != 2'b11) c_m++;
          e = '{window: w_m, pulse: m, count: c_m};
          q_b.push_back(e);
        end
        tick();
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL sat_timeout: done never seen, required within 30 cycles");
    end
    vectors++;
    if (n_shift !== 8 || pulses !== 7) begin
      miscompares++;
      $display("FAIL sat_counts: shifts=%0d pulses=%0d, required 8 7", n_shift, pulses);
    end
    vectors++;
    if (ifb.match_count !== 2'd3 || ifb.window !== 2'b11) begin
      miscompares++;
      $display("FAIL sat_final: count=%0d window=%b, required 3 11", ifb.match_count, ifb.window);
    end
    tick();
    tick();
  endtask

`ifdef LFSR_MON_HOLD_EN
  task automatic test_hold();
    int lat, n_shift, done_cyc;
    logic [11:0] pmask;
    run_a(stream_a, -1, 6, 3, lat, n_shift, pmask, done_cyc);
    check_a_summary("hold", n_shift, pmask, done_cyc, 15);
    tick();
    tick();
  endtask
`endif

  initial begin
    rst_n      = 1'b1;
    ifa.start  = 1'b0;
    ifa.bit_in = 1'b0;
    ifb.start  = 1'b0;
    ifb.bit_in = 1'b1;
`ifdef LFSR_MON_HOLD_EN
    ifa.hold = 1'b0;
    ifb.hold = 1'b0;
`endif
    stream_a = 12'b1111_0110_1101;
    test_reset();
    test_pattern_count();
    test_start_handling();
    test_reset_mid();
    test_saturation();
`ifdef LFSR_MON_HOLD_EN
    test_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
